seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Time-multiplexed driver for the board's 4-digit, common-anode seven-segment display.
- Sits directly downstream of the alarm-clock controller. It takes four hex/BCD nibbles plus per-digit decimal-point and blank flags, and drives the active-low seg/an/dp pins.
- Cycles one digit per refresh slot. A programmable anode-off guard interval at the start of each slot suppresses ghosting.

Parameters:
- REFRESH_COUNT, 50000: clock cycles per digit slot (50 MHz gives 1 kHz per digit, 4 ms per full scan). Legal range is 2 or more.
- GUARD, 16: cycles at the start of each slot with all anodes off. Legal range is 0 to REFRESH_COUNT-1.
- BLINK_SCANS, 125: full scans per blink half-period. Used only with SEG7_BLINK_EN.

Ports:
- MCLK  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- digits  input  16  digit i = digits[4i+3:4i]; digit 0 is the rightmost
- dp_in  input  4  dp_in[i]=1 lights the decimal point of digit i
- blank  input  4  blank[i]=1 keeps digit i dark
- blink  input  4  blink[i]=1 makes digit i blink (SEG7_BLINK_EN only; ignored otherwise)
- seg  output  7  active-low segments; seg[0]=a … seg[6]=g
- an  output  4  active-low anodes; an[i] enables digit i
- dp  output  1  active-low decimal point

Behaviour:
- Reset is synchronous and active-high. At the edge where reset=1:
  - cnt=0, idx=0
  - seg=7'h7F, an=4'hF, dp=1
  - blink phase=0
- Reset overrides all other activity, including mid-slot.
- cnt counts 0..REFRESH_COUNT-1 and then wraps to 0. At the edge where cnt==REFRESH_COUNT-1, idx advances 0→1→2→3→0; the 3→0 step is modulo 4.
- All outputs are registered. Edge rules, using pre-edge values:
  - cnt==GUARD: load digit idx. an = one-hot-low(idx), seg = decode(digits nibble idx), dp = ~dp_in[idx]. If blank[idx]=1 (or the blink condition holds), instead load an=4'hF, seg=7'h7F, dp=1.
  - cnt==REFRESH_COUNT-1 and GUARD>0: an=4'hF, seg=7'h7F, dp=1 (guard blanking).
  - Otherwise all outputs hold.
- Inputs are sampled only at the cnt==GUARD edge. Changes mid-slot are not visible until that digit's next slot, so there is no tearing.
- Visible timing within a slot, counting cycles by cnt value:
  - GUARD>0: dark during cycles 0..GUARD, digit shown during cycles GUARD+1..REFRESH_COUNT-1.
  - GUARD=0: digit shown from cycle 1 through cycle 0 of the next slot.
  - Output latency from the sampling edge is 1 cycle.
- A blanked digit still consumes its full slot. The scan order never skips a slot.
- Decode table, active-low, written as g..a in hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- No two an bits are ever low at the same time.

Optional Feature:
- Macro name: SEG7_BLINK_EN.
- With the macro defined:
  - A scan counter increments at every idx 3→0 wrap.
  - On reaching BLINK_SCANS-1, the scan counter clears and the blink phase toggles.
  - While phase=1, any digit with blink[i]=1 loads as blank at its cnt==GUARD edge.
  - The phase is 0 after reset, so blinking digits start visible.
- Without the macro: no scan counter and no phase register. The blink port exists but is ignored, and behaviour is identical to blink=4'h0.

Test Plan (REFRESH_COUNT=8, GUARD=2, BLINK_SCANS=2):
- Reset: hold reset 3 cycles, then release → an=F, seg=7F, dp=1 until the edge after cnt==2; then an=E.
- digits=16'h1234, dp_in=4'b0010, blank=0 → slot 0: an=E, seg=19, dp=1. Slot 1: an=D, seg=30, dp=0. Slot 2: an=B, seg=24. Slot 3: an=7, seg=79. Each digit is shown 5 cycles and dark 3 cycles; pattern repeats every 32 cycles.
- Change digits from 16'h1234 to 16'h5678 at cnt==4 of slot 0 → seg stays 19 for the rest of that slot. Slot 1 shows 7 (seg=78).
- blank=4'b0100 → over 32 cycles an is never B; during slot 2 an=F, seg=7F. Slot 3 starts on schedule at cycle 24.
- Assert reset at cnt==5 of slot 2 → the next cycle shows an=F, seg=7F. After release, slot 0 (an=E) appears at cycle 3.
- SEG7_BLINK_EN defined, blink=4'b0001 → digit 0 is visible in scans 0–1, dark in scans 2–3, visible again in scan 4. Digits 1–3 are unaffected. With the macro undefined, digit 0 is visible in every scan.

Source files
------------

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display-data bundle between the alarm-clock controller
// (master) and the seven-segment scan driver (slave).
interface seg7_scan_if;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    modport master (
        output digits, dp_in, blank, blink,
        input  seg, an, dp
    );

    modport slave (
        input  digits, dp_in, blank, blink,
        output seg, an, dp
    );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. One digit per refresh slot, with an anode-off
// guard interval at the start of each slot to suppress ghosting.
// All pins (seg/an/dp) are active-low and registered.
// Optional feature: define SEG7_BLINK_EN to enable per-digit blinking,
// with a blink half-period of BLINK_SCANS full scans.
module seg7_scan #(
    parameter int REFRESH_COUNT = 50000,
    parameter int GUARD         = 16,
    parameter int BLINK_SCANS   = 125
) (
    input  logic        MCLK,
    input  logic        reset,
    seg7_scan_if.slave  bus
);

    localparam int CNT_W = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_COUNT - 1);
    localparam logic [CNT_W-1:0] GUARD_AT  = CNT_W'(GUARD);
    localparam bit               HAS_GUARD = (GUARD > 0);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [6:0]       seg_q;
    logic [3:0]       an_q;
    logic             dp_q;
    logic             dark;
    logic             slot_end;
    logic             scan_end;

    // Hex nibble to active-low segment pattern, bits ordered g..a.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign scan_end = slot_end && (idx == 2'd3);

`ifdef SEG7_BLINK_EN
    localparam int SCAN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(BLINK_SCANS - 1);

    logic [SCAN_W-1:0] scan_cnt;
    logic              phase;

    // Count completed scans; flip the blink phase every BLINK_SCANS scans.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            scan_cnt <= '0;
            phase    <= 1'b0;
        end else if (scan_end) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                phase    <= ~phase;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    assign dark = bus.blank[idx] | (phase & bus.blink[idx]);
`else
    logic unused_blink;

    assign dark         = bus.blank[idx];
    assign unused_blink = ^{bus.blink, BLINK_SCANS[0], scan_end};
`endif

    // Slot timer and digit pointer; idx wraps 3 -> 0 naturally in 2 bits.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Output registers: load the current digit once per slot, blank at slot end.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            seg_q <= 7'h7F;
            an_q  <= 4'hF;
            dp_q  <= 1'b1;
        end else if (cnt == GUARD_AT) begin
            if (dark) begin
                seg_q <= 7'h7F;
                an_q  <= 4'hF;
                dp_q  <= 1'b1;
            end else begin
                seg_q <= decode(bus.digits[{idx, 2'b00} +: 4]);
                an_q  <= ~(4'b0001 << idx);
                dp_q  <= ~bus.dp_in[idx];
            end
        end else if (HAS_GUARD && slot_end) begin
            seg_q <= 7'h7F;
            an_q  <= 4'hF;
            dp_q  <= 1'b1;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed self-checking bench for seg7_scan with
// REFRESH_COUNT=8, GUARD=2, BLINK_SCANS=2. Expected blink behaviour
// follows whether SEG7_BLINK_EN is defined for the build.
module tb_seg7_scan;

    localparam int REFRESH_COUNT = 8;
    localparam int GUARD         = 2;
    localparam int BLINK_SCANS   = 2;

`ifdef SEG7_BLINK_EN
    localparam bit BLINK_BUILD = 1'b1;
`else
    localparam bit BLINK_BUILD = 1'b0;
`endif

    logic MCLK;
    logic reset;
    int   testsRun;
    int   testsFailed;

    seg7_scan_if bus ();

    seg7_scan #(
        .REFRESH_COUNT (REFRESH_COUNT),
        .GUARD         (GUARD),
        .BLINK_SCANS   (BLINK_SCANS)
    ) dut (
        .MCLK  (MCLK),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-time-unit clock.
    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // Advance n rising edges and settle just past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv,
                                 input logic [3:0] bl, input logic [3:0] bk);
        bus.digits = d;
        bus.dp_in  = dpv;
        bus.blank  = bl;
        bus.blink  = bk;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectDisplay(input string tag, input logic [3:0] an_e,
                                 input logic [6:0] seg_e, input logic dp_e);
        checkOutput({tag, ".an"},  int'(bus.an),  int'(an_e));
        checkOutput({tag, ".seg"}, int'(bus.seg), int'(seg_e));
        checkOutput({tag, ".dp"},  int'(bus.dp),  int'(dp_e));
    endtask

    initial begin
        int bHits;
        bit blinkDark;
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        applyStimulus(16'h1234, 4'b0010, 4'b0000, 4'b0000);

        // Reset held three cycles, then released.
        tick(3);
        expectDisplay("reset", 4'hF, 7'h7F, 1'b1);
        reset = 1'b0;
        tick(1);
        expectDisplay("guard_c1", 4'hF, 7'h7F, 1'b1);
        tick(1);
        expectDisplay("guard_c2", 4'hF, 7'h7F, 1'b1);
        tick(1);                                   // k=3
        expectDisplay("slot0", 4'hE, 7'h19, 1'b1);
        tick(4);                                   // k=7
        expectDisplay("slot0_end", 4'hE, 7'h19, 1'b1);
        tick(1);                                   // k=8
        expectDisplay("guard_blank", 4'hF, 7'h7F, 1'b1);
        tick(3);                                   // k=11
        expectDisplay("slot1", 4'hD, 7'h30, 1'b0);
        tick(8);                                   // k=19
        expectDisplay("slot2", 4'hB, 7'h24, 1'b1);
        tick(8);                                   // k=27
        expectDisplay("slot3", 4'h7, 7'h79, 1'b1);
        tick(8);                                   // k=35
        expectDisplay("wrap_slot0", 4'hE, 7'h19, 1'b1);

        // Mid-slot digit change must not tear the current slot.
        tick(1);                                   // k=36, cnt=4
        applyStimulus(16'h5678, 4'b0010, 4'b0000, 4'b0000);
        tick(1);
        expectDisplay("no_tear", 4'hE, 7'h19, 1'b1);
        tick(2);                                   // k=39
        expectDisplay("no_tear_end", 4'hE, 7'h19, 1'b1);
        tick(4);                                   // k=43
        expectDisplay("new_slot1", 4'hD, 7'h78, 1'b0);

        // Blank digit 2: slot kept, but dark.
        applyStimulus(16'h5678, 4'b0010, 4'b0100, 4'b0000);
        tick(8);                                   // k=51
        expectDisplay("blank_slot2", 4'hF, 7'h7F, 1'b1);
        tick(4);                                   // k=55
        expectDisplay("blank_slot2_late", 4'hF, 7'h7F, 1'b1);
        tick(4);                                   // k=59
        expectDisplay("after_blank", 4'h7, 7'h12, 1'b1);
        bHits = 0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (bus.an == 4'hB) bHits++;
        end                                        // k=91
        checkOutput("blank_never_B", bHits, 0);
        applyStimulus(16'h5678, 4'b0010, 4'b0000, 4'b0000);

        // Reset in the middle of slot 2.
        tick(26);                                  // k=117, slot 2, cnt=5
        expectDisplay("pre_reset", 4'hB, 7'h02, 1'b1);
        reset = 1'b1;
        tick(1);
        expectDisplay("mid_reset", 4'hF, 7'h7F, 1'b1);
        reset = 1'b0;
        tick(2);
        expectDisplay("post_reset_guard", 4'hF, 7'h7F, 1'b1);
        tick(1);
        expectDisplay("post_reset_slot0", 4'hE, 7'h00, 1'b1);

        // Blink digit 0, from a fresh reset so scan counting starts at 0.
        applyStimulus(16'h5678, 4'b0010, 4'b0000, 4'b0001);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);                                   // k=3
        for (int s = 0; s < 5; s++) begin
            blinkDark = BLINK_BUILD && (s == 2 || s == 3);
            if (blinkDark)
                expectDisplay($sformatf("blink_d0_s%0d", s), 4'hF, 7'h7F, 1'b1);
            else
                expectDisplay($sformatf("blink_d0_s%0d", s), 4'hE, 7'h00, 1'b1);
            tick(8);
            expectDisplay($sformatf("blink_d1_s%0d", s), 4'hD, 7'h78, 1'b0);
            tick(24);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
